lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side counterpart of the fibonacci LFSR generator: takes the pseudo-random word stream and self-synchronises by seeding from the received data.
- Once locked, it predicts every following word and counts mismatches.
- Sits at the far end of a PRN link or loopback, one strobe per word, and feeds lock/error status to LEDs or the seven-segment display.
- Uses the same polynomial and shift direction as the generator.

Parameters:
- WIDTH, 8, word width of the PRN stream.
- TAPS, 8'hB8, feedback tap mask: fb = XOR-reduce(word & TAPS); the default uses bits 7,5,4,3.
- LOCK_COUNT, 3, consecutive correct predictions required to declare lock.
- MISS_LIMIT, 4, consecutive mismatches while locked that force a resync.
- CNT_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- prn_in  input  WIDTH  received pseudo-random word.
- prn_valid  input  1  one-cycle strobe; prn_in is sampled on the clock edge where it is high.
- err_clear  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatch while LOCKED.
- zero_err  output  1  one-cycle pulse when an all-zeros word is received in any state.
- err_count  output  CNT_WIDTH  saturating count of mismatches while LOCKED.

Behaviour:
- Next-state function: next(w) = {w[WIDTH-2:0], ^(w & TAPS)}.
- Internal state: expected word register (WIDTH), match counter, miss counter, FSM state.
- Reset: FSM=IDLE; expected=0; both counters=0; locked=0; err_pulse=0; zero_err=0; err_count=0.
- All outputs are registered and update on the edge that samples prn_valid; the result is visible the following cycle (1-cycle latency).
- With prn_valid low, no state changes; err_pulse and zero_err return to 0.
- IDLE, valid with prn_in==0: zero_err=1; stay in IDLE.
- IDLE, valid with prn_in!=0: expected<=next(prn_in); match=0; go to ACQUIRE.
- ACQUIRE, valid with prn_in==expected: expected<=next(prn_in); match++.
- ACQUIRE, on the LOCK_COUNT-th consecutive match: go to LOCKED; locked=1 on the next cycle; miss=0.
- ACQUIRE, valid with a nonzero mismatch: reseed: expected<=next(prn_in); match=0; stay in ACQUIRE. No err_pulse.
- ACQUIRE, valid with prn_in==0: zero_err=1; go to IDLE.
- LOCKED (flywheel): expected<=next(expected) every valid, regardless of prn_in; no reseeding.
- LOCKED, match: miss=0.
- LOCKED, mismatch (including prn_in==0, which also pulses zero_err): err_pulse=1; err_count+1, saturating at all-ones; miss++.
- LOCKED, when miss reaches MISS_LIMIT: go to IDLE; locked=0; err_count holds its value.
- err_clear: err_count<=0 on that edge. If err_clear and a counted mismatch occur on the same edge, err_count<=1 (the clear wins, then the new error counts). err_pulse is unaffected.
- Reset asserted mid-operation: immediate return to reset values, whatever the state.
- Back-to-back valids on consecutive cycles are supported; valid may be sparse (gaps of any length).

Test Plan:
- Seed and lock: after reset, valid words 0x01,0x02,0x04,0x08 -> locked rises one cycle after the 0x08 strobe. Then 0x11,0x23 -> no err_pulse; err_count=0.
- Single bit error: while locked and expecting 0x23, send 0x22, then resume the correct sequence (0x47 for next(0x23)) -> one err_pulse; err_count=1; locked stays 1; miss resets to 0.
- Loss of lock: while locked, 4 consecutive wrong words -> 4 err_pulses; err_count=4; locked falls after the 4th. A new valid sequence relocks after 1+LOCK_COUNT words; err_count stays 4.
- Zero handling: send 0x00 in IDLE -> zero_err pulse, locked stays 0. Send 0x00 while locked -> zero_err and err_pulse on the same cycle, err_count+1.
- ACQUIRE reseed: 0x01,0x02,0x55,next(0x55),... -> no err_pulse; lock is declared only after 3 consecutive matches following 0x55.
- Saturation, clear and reset: force 2^CNT_WIDTH+5 errors (bench with CNT_WIDTH=4) -> err_count holds 0xF. Pulse err_clear together with an error -> err_count=1. Assert reset while locked -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side PRN checker: seeds from the incoming Fibonacci LFSR stream and acquires lock.
// Once locked it flywheels the prediction and counts word mismatches.
module lfsr_checker #(
  parameter int unsigned     WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
  parameter int unsigned     LOCK_COUNT = 3,
  parameter int unsigned     MISS_LIMIT = 4,
  parameter int unsigned     CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     prn_in,
  input  logic                 prn_valid,
  input  logic                 err_clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 zero_err,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t             state;
  logic [WIDTH-1:0]   expected;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               is_zero_c;
  logic               is_match_c;
  logic               count_err_c;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
    return {w[WIDTH-2:0], ^(w & TAPS)};
  endfunction

  assign is_zero_c   = (prn_in == '0);
  assign is_match_c  = (prn_in == expected);
  assign count_err_c = prn_valid && (state == LOCKED) && !is_match_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      zero_err  <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      zero_err  <= 1'b0;

      if (prn_valid) begin
        case (state)
          IDLE: begin
            if (is_zero_c) begin
              zero_err <= 1'b1;
            end else begin
              expected  <= lfsr_next(prn_in);
              match_cnt <= '0;
              state     <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (is_zero_c) begin
              zero_err <= 1'b1;
              state    <= IDLE;
            end else if (is_match_c) begin
              expected <= lfsr_next(prn_in);
              if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
              end
            end else begin
              // Reseed from the received word; errors are not counted before lock.
              expected  <= lfsr_next(prn_in);
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction never follows the received data once locked.
            expected <= lfsr_next(expected);
            if (is_match_c) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              zero_err  <= is_zero_c;
              if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                state    <= IDLE;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Clear wins over the running total, but an error on the same edge still counts.
      if (err_clear) begin
        err_count <= count_err_c ? CNT_WIDTH'(1) : '0;
      end else if (count_err_c && (err_count != '1)) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with a behavioural reference model and an expectation queue.
module tb_lfsr_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] prn_in;
  logic             prn_valid;
  logic             err_clear;
  logic             locked;
  logic             err_pulse;
  logic             zero_err;
  logic [CW-1:0]    err_count;

  typedef struct {
    logic          locked;
    logic          err_pulse;
    logic          zero_err;
    logic [CW-1:0] err_count;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: 0 idle, 1 acquire, 2 locked.
  int   m_state;
  int   m_exp;
  int   m_match;
  int   m_miss;
  int   m_cnt;
  bit   m_locked, m_errp, m_zero;

  lfsr_checker #(.WIDTH(WIDTH), .TAPS(8'hB8), .LOCK_COUNT(3), .MISS_LIMIT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .prn_in(prn_in), .prn_valid(prn_valid), .err_clear(err_clear),
    .locked(locked), .err_pulse(err_pulse), .zero_err(zero_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic int ref_next(input int w);
    int fb = 0;
    if (w & 8'h80) fb ^= 1;
    if (w & 8'h20) fb ^= 1;
    if (w & 8'h10) fb ^= 1;
    if (w & 8'h08) fb ^= 1;
    return ((w << 1) & 8'hFF) | fb;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_match = 0; m_miss = 0; m_cnt = 0;
    m_locked = 0; m_errp = 0; m_zero = 0;
  endtask

  task automatic model_step(input bit v, input int w, input bit clr);
    bit counted = 0;
    m_errp = 0;
    m_zero = 0;
    if (v) begin
      if (m_state == 0) begin
        if (w == 0) m_zero = 1;
        else begin m_exp = ref_next(w); m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (w == 0) begin m_zero = 1; m_state = 0; end
        else if (w == m_exp) begin
          m_exp = ref_next(w);
          m_match++;
          if (m_match == 3) begin m_state = 2; m_miss = 0; m_match = 0; end
        end else begin m_exp = ref_next(w); m_match = 0; end
      end else begin
        if (w != m_exp) begin
          counted = 1;
          m_errp = 1;
          m_zero = (w == 0);
          m_miss++;
          if (m_miss == 4) begin m_state = 0; m_miss = 0; end
        end else m_miss = 0;
        m_exp = ref_next(m_exp);
      end
    end
    if (clr) m_cnt = counted ? 1 : 0;
    else if (counted && m_cnt < 15) m_cnt++;
    m_locked = (m_state == 2);
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue the model's prediction, then compare just after the edge.
  task automatic step(input bit v, input int w, input bit clr);
    exp_t e;
    prn_valid = v;
    prn_in    = WIDTH'(w);
    err_clear = clr;
    model_step(v, w, clr);
    e.locked = m_locked; e.err_pulse = m_errp; e.zero_err = m_zero; e.err_count = CW'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    prn_valid = 1'b0;
    err_clear = 1'b0;
    e = sb.pop_front();
    check("locked",    int'(locked),    int'(e.locked));
    check("err_pulse", int'(err_pulse), int'(e.err_pulse));
    check("zero_err",  int'(zero_err),  int'(e.zero_err));
    check("err_count", int'(err_count), int'(e.err_count));
  endtask

  task automatic send(input int w);
    step(1'b1, w, 1'b0);
  endtask

  task automatic send_good();
    step(1'b1, m_exp, 1'b0);
  endtask

  task automatic send_bad(input bit clr);
    step(1'b1, m_exp ^ 1, clr);
  endtask

  initial begin
    reset = 1'b1; prn_in = '0; prn_valid = 1'b0; err_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_err_pulse", int'(err_pulse), 0);
    check("rst_zero_err", int'(zero_err), 0);
    check("rst_err_count", int'(err_count), 0);
    reset = 1'b0;

    // Zero in IDLE, then seed and lock with a sparse gap.
    step(1'b0, 0, 1'b0);
    send(8'h00);
    check("idle_zero_pulse", int'(zero_err), 1);
    send(8'h01); send(8'h02);
    step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);
    send(8'h04);
    check("not_locked_yet", int'(locked), 0);
    send(8'h08);
    check("locked_after_08", int'(locked), 1);
    send(8'h11);
    send(8'h22);
    check("single_err_pulse", int'(err_pulse), 1);
    send(8'h47);
    check("single_err_count", int'(err_count), 1);
    check("still_locked", int'(locked), 1);

    // Three misses, then a hit: miss counter resets, lock holds.
    send_bad(0); send_bad(0); send_bad(0); send_good();
    check("miss_reset_lock", int'(locked), 1);

    // Zero word while locked counts as an error too.
    send(8'h00);
    check("lock_zero_both", int'(zero_err & err_pulse), 1);
    send_good();

    // Four consecutive misses drop lock.
    send_bad(0); send_bad(0); send_bad(0);
    check("locked_after_3_miss", int'(locked), 1);
    send_bad(0);
    check("lost_lock", int'(locked), 0);
    check("count_after_loss", int'(err_count), 9);

    // Reseed in ACQUIRE: lock only after three matches following 0x55.
    send(8'h01); send(8'h02); send(8'h55);
    send_good(); send_good();
    check("reseed_no_lock", int'(locked), 0);
    send_good();
    check("reseed_locked", int'(locked), 1);
    check("reseed_count_held", int'(err_count), 9);

    // Saturation: alternate errors and good words.
    for (int i = 0; i < 21; i++) begin
      send_bad(0);
      send_good();
    end
    check("saturated", int'(err_count), 15);

    // Clear coincident with an error, then clear alone.
    send_bad(1);
    check("clear_with_err", int'(err_count), 1);
    step(1'b0, 0, 1'b1);
    check("clear_alone", int'(err_count), 0);
    send_good();

    // Asynchronous reset while locked.
    send_bad(0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_err_pulse", int'(err_pulse), 0);
    check("async_rst_count", int'(err_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h00);
    send(8'h2A);
    check("post_rst_unlocked", int'(locked), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
